// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// two producers (A = ALU results, B = load/store / multi-cycle results).
// Each producer feeds a DEPTH-entry in-order queue. Queues are drained
// round-robin, one entry per cycle, through a registered output stage.
// A combinational scoreboard exposes every write that is queued or staged.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   a_valid/a_ready       port A handshake; a_rd, a_wdata carry the write
//   b_valid/b_ready       port B handshake; b_rd, b_wdata carry the write
//   rf_we/rf_rd/rf_wdata  register-file write port (registered)
//   pending[31:0]         bit r set while a write to r is queued or staged

// Per-producer queue. It also reports a one-hot OR of the rd of every
// valid entry, which feeds the scoreboard.
module regfile_wb_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_valid,
    input  logic [4:0]      push_rd,
    input  logic [XLEN-1:0] push_wdata,
    output logic            ready,
    input  logic            pop,
    output logic            nonempty,
    output logic [4:0]      head_rd,
    output logic [XLEN-1:0] head_wdata,
    output logic [31:0]     pend
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][4:0]      rd_mem;
    logic [DEPTH-1:0][XLEN-1:0] wd_mem;
    logic [AW-1:0]              wptr, rptr;
    logic [AW:0]                cnt;
    logic                       full, push;
    logic [AW-1:0]              off;

    // Readiness comes only from registered occupancy; a full queue refuses
    // a push even in a cycle where it is also popping.
    assign full       = (cnt == (AW+1)'(DEPTH));
    assign ready      = !full;
    assign push       = push_valid && !full;
    assign nonempty   = (cnt != '0);
    assign head_rd    = rd_mem[rptr];
    assign head_wdata = wd_mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                rd_mem[wptr] <= push_rd;
                wd_mem[wptr] <= push_wdata;
                wptr         <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Slot i holds a live entry when its distance from the read pointer
    // (mod DEPTH) is below the occupancy.
    always_comb begin
        pend = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr;
            if ({1'b0, off} < cnt)
                pend[rd_mem[i]] = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_wdata,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_wdata,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);
    localparam int NPORT = 2;  // index 0 = port A, 1 = port B

    logic [NPORT-1:0]           in_valid, q_ready, q_pop, q_ne;
    logic [NPORT-1:0][4:0]      in_rd, q_rd;
    logic [NPORT-1:0][XLEN-1:0] in_wdata, q_wdata;
    logic [NPORT-1:0][31:0]     q_pend;

    assign in_valid = {b_valid, a_valid};
    assign in_rd    = {b_rd, a_rd};
    assign in_wdata = {b_wdata, a_wdata};

    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_q
            regfile_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_q (
                .clk        (clk),
                .reset      (reset),
                .push_valid (in_valid[p]),
                .push_rd    (in_rd[p]),
                .push_wdata (in_wdata[p]),
                .ready      (q_ready[p]),
                .pop        (q_pop[p]),
                .nonempty   (q_ne[p]),
                .head_rd    (q_rd[p]),
                .head_wdata (q_wdata[p]),
                .pend       (q_pend[p])
            );
        end
    endgenerate

    // last_grant: 0 = A, 1 = B. On a tie the port not granted last wins.
    logic            last_grant;
    logic            gnt_a, gnt_b, any_gnt;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_wdata;
    logic            we_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] wd_q;
    logic [31:0]     stage_pend;

    assign gnt_a     = q_ne[0] && (!q_ne[1] || last_grant);
    assign gnt_b     = q_ne[1] && !gnt_a;
    assign q_pop     = {gnt_b, gnt_a};
    assign any_gnt   = gnt_a || gnt_b;
    assign sel_rd    = gnt_b ? q_rd[1]    : q_rd[0];
    assign sel_wdata = gnt_b ? q_wdata[1] : q_wdata[0];

    // x0 entries still take their grant slot; they only suppress rf_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wd_q       <= '0;
        end else begin
            we_q <= any_gnt && (sel_rd != 5'd0);
            if (any_gnt) begin
                last_grant <= gnt_b;
                rd_q       <= sel_rd;
                wd_q       <= sel_wdata;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, not just after the
    // reset edge, so decode sees no stale state during reset.
    assign a_ready    = !reset && q_ready[0];
    assign b_ready    = !reset && q_ready[1];
    assign rf_we      = !reset && we_q;
    assign rf_rd      = reset ? 5'd0 : rd_q;
    assign rf_wdata   = reset ? '0   : wd_q;
    assign stage_pend = we_q ? (32'd1 << rd_q) : 32'd0;
    assign pending    = reset ? 32'd0
                              : ((q_pend[0] | q_pend[1] | stage_pend) & ~32'd1);
endmodule
